// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

    localparam int UART_WIDTH      = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FIFO_DEPTH = 8;

    // Bit 1 = accepted write, bit 0 = pop.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH,
    parameter  int WIDTH = UART_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind uart_receiver: FWFT output stream, occupancy
// count, and a sticky flag for bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH,
    parameter  int WIDTH = UART_WIDTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLKIN,
    input  logic             RESET,
    input  logic             clock_enable,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             overflow_clear
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic          rx_ready_q, rx_ready_d;
    logic          overflow_q, overflow_d;

    logic     push_s, pop_s, full_s, wr_en_s, drop_s;
    fifo_op_e op_s;

    // rx_valid spans many CLKIN cycles but meets clock_enable exactly once.
    assign push_s  = rx_valid & clock_enable;
    assign pop_s   = out_valid_q & out_ready;
    assign full_s  = (count_q == FULL_CNT);
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;
    assign op_s    = fifo_op_e'({wr_en_s, pop_s});

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (CLKIN),
        .we    (wr_en_s & ~RESET),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    // Next-state for pointers, occupancy, status flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op_s)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
                count_d = count_q;
            end
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        out_valid_d = (count_d != {CW{1'b0}});
        rx_ready_d  = (count_d < FULL_CNT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            rx_ready_q  <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            rx_ready_q  <= rx_ready_d;
            overflow_q  <= overflow_d;
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign rx_ready  = rx_ready_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of uart_receiver.
- Captures each byte on the receiver's single-enabled-cycle valid pulse.
- Backpressures the receiver via its `ready` input (sampled only at start-bit detect).
- Presents bytes to the system side as a first-word-fall-through valid/ready stream, with occupancy count and sticky overflow flag.

Parameters:
- DEPTH, 8, number of byte entries; power of two, ≥ 2.
- WIDTH, 8, data width; matches the receiver byte.
- CW, $clog2(DEPTH+1), count width (derived, localparam).

Ports:
- CLKIN  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- clock_enable  in  1  same oversample enable that drives uart_receiver.
- rx_data  in  WIDTH  receiver `data`.
- rx_valid  in  1  receiver `valid`; high for exactly one clock_enable period.
- rx_ready  out  1  to receiver `ready`; "space available".
- out_data  out  WIDTH  head-of-FIFO byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a byte was dropped.
- overflow_clear  in  1  clears overflow.

Behaviour:
- One clock CLKIN; reset is synchronous and active-high (RESET); all state updates on posedge CLKIN.
- Reset values: count=0, write/read pointers=0, out_valid=0, rx_ready=1, overflow=0, out_data=don't-care (memory not cleared).
- Push event: push = rx_valid & clock_enable. This yields exactly one push per received byte, because rx_valid stays high across several CLKIN cycles but coincides with clock_enable only once.
- Pop event: pop = out_valid & out_ready. Pop is independent of clock_enable.
- FWFT output:
  - out_data = mem[rd_ptr] combinationally from registered memory and pointer.
  - out_valid = (count != 0).
  - A byte pushed on edge k is visible at out_valid/out_data after edge k (1-cycle latency).
- rx_ready = (count < DEPTH), registered-equivalent (derived from registered count).
  - The receiver samples ready only at start-bit detect and carries at most one byte in flight, so ready high at start guarantees space.
- Pointers: log2(DEPTH)-bit, wrap naturally from DEPTH-1 to 0.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged; both pointers advance.
- Full (count==DEPTH):
  - push without pop: byte dropped; memory, pointers and count unchanged; overflow←1.
  - push with pop: both accepted; count stays DEPTH; no overflow.
- Empty (count==0):
  - pop is impossible (out_valid=0); out_ready ignored.
  - push while empty: stored; out_valid rises next cycle. No bypass/combinational path from rx to out.
- Overflow:
  - Set on dropped push.
  - overflow_clear clears it.
  - Same-cycle set and clear: set wins (overflow=1).
- RESET mid-operation: discards all contents regardless of push/pop in the same cycle. The receiver may still be mid-byte; its later pulse is accepted normally.
- clock_enable low: no effect on the pop side; pushes are blocked.

Decomposition:
- Shared package uart_pkg:
  - UART_WIDTH=8.
  - UART_OVERSAMPLE=16.
  - Default FIFO depth constant.
- One natural sub-module: uart_fifo_mem.
  - Simple dual-port register array: write port (we, waddr, wdata), async read port (raddr→rdata).
- Pointer/count/flag control stays in uart_rx_fifo.

Test Plan:
- Reset then single byte: rx_data=0x5A, rx_valid high 16 CLKIN with clock_enable every 16th -> exactly one push; count=1, out_valid=1, out_data=0x5A; out_ready pulse -> count=0, out_valid=0.
- Fill: 8 pulses 0x01..0x08, out_ready=0 -> count=8, rx_ready=0, overflow=0; drain with out_ready=1 -> 0x01..0x08 in order, one per cycle, rx_ready=1 after first pop.
- Overflow: full with 0x01..0x08, push 0x99 -> overflow=1, count=8, drained sequence still 0x01..0x08; overflow_clear -> overflow=0.
- Simultaneous at full: count=8, push 0xAA in same cycle as pop -> count=8, overflow=0; final drained byte is 0xAA.
- Wrap-around: 20 bytes (0x10..0x23) streamed with interleaved pops keeping count ≤ 3 -> all 20 emitted in order, no loss.
- Reset mid-stream: count=5, assert RESET one cycle concurrent with push and pop -> count=0, out_valid=0, overflow=0, rx_ready=1; next push 0x33 is read back as 0x33.
